// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the fifo_ram access sequencer: FSM encoding,
// size defaults and the one-hot grant codes used by the round-robin arbiters.
package fifo_ctrl_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int DEPTH_DEF       = 16384;
  localparam int LEVEL_WIDTH_DEF = 15;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_W_SETUP   = 4'd1,
    ST_W_STROBE  = 4'd2,
    ST_W_HOLD    = 4'd3,
    ST_R_SETUP   = 4'd4,
    ST_R_STROBE  = 4'd5,
    ST_R_HOLD    = 4'd6,
    ST_R_CAPTURE = 4'd7,
    ST_CLEAR     = 4'd8
  } state_e;

  // Requester 0 is the write class / writer A, requester 1 the read class / writer B.
  localparam logic [1:0] GRANT_0 = 2'b01;
  localparam logic [1:0] GRANT_1 = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer names the requester preferred on
// contention and moves to the other one after a grant is taken.
module rr_arbiter2 #(
  parameter bit ALWAYS_FLIP = 1'b1  // 0: pointer only moves when both requested
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // NOTE: clocked state uses non-blocking assignments only; blocking is kept for always_comb.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (advance && (ALWAYS_FLIP || req == 2'b11)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/fifo_ram_arbiter.sv
// Sequences the single-port fifo_ram for two writers and one reader: enable
// setup, one-cycle strobe, hold; fair arbitration, fill level and soft clear.
module fifo_ram_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  a_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [DATA_WIDTH-1:0]  b_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic                   rd_req,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  input  logic                   clear,
  output logic [DATA_WIDTH-1:0]  fifo_data_in,
  output logic                   fifo_write,
  output logic                   fifo_read,
  output logic                   fifo_enable,
  output logic                   fifo_reset,
  input  logic [DATA_WIDTH-1:0]  fifo_data_out,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   busy
);

  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = LEVEL_WIDTH'(DEPTH);

  state_e     state;
  logic       clear_pending;
  logic       wr_elig;
  logic       rd_elig;
  logic       go_clear;
  logic       grant_any;
  logic [1:0] cls_grant;
  logic [1:0] wr_grant;

  // Flags are only looked at in IDLE; by then a finished access has settled them.
  assign wr_elig   = (a_valid | b_valid) & ~fifo_full;
  assign rd_elig   = rd_req & ~fifo_empty;
  assign go_clear  = clear | clear_pending;
  assign grant_any = (state == ST_IDLE) & ~go_clear & (wr_elig | rd_elig);
  assign busy      = (state != ST_IDLE);

  rr_arbiter2 #(.ALWAYS_FLIP(1'b1)) u_class_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({rd_elig, wr_elig}),
    .advance (grant_any),
    .grant   (cls_grant)
  );

  rr_arbiter2 #(.ALWAYS_FLIP(1'b0)) u_writer_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({b_valid, a_valid}),
    .advance (grant_any && cls_grant == GRANT_0),
    .grant   (wr_grant)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      clear_pending <= 1'b0;
      a_ready       <= 1'b0;
      b_ready       <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      fifo_data_in  <= '0;
      fifo_write    <= 1'b0;
      fifo_read     <= 1'b0;
      fifo_enable   <= 1'b0;
      fifo_reset    <= 1'b0;
      level         <= '0;
    end else begin
      a_ready    <= 1'b0;
      b_ready    <= 1'b0;
      rd_valid   <= 1'b0;
      fifo_write <= 1'b0;
      fifo_read  <= 1'b0;
      fifo_reset <= 1'b0;

      // A clear seen mid-access waits for the access to finish.
      if (clear && state != ST_IDLE && state != ST_CLEAR) clear_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (go_clear) begin
            state         <= ST_CLEAR;
            clear_pending <= 1'b0;
            fifo_reset    <= 1'b1;
            fifo_enable   <= 1'b0;
            level         <= '0;
          end else if (grant_any && cls_grant == GRANT_0) begin
            state       <= ST_W_SETUP;
            fifo_enable <= 1'b1;
            if (wr_grant == GRANT_1) begin
              fifo_data_in <= b_data;
              b_ready      <= 1'b1;
            end else begin
              fifo_data_in <= a_data;
              a_ready      <= 1'b1;
            end
          end else if (grant_any && cls_grant == GRANT_1) begin
            state       <= ST_R_SETUP;
            fifo_enable <= 1'b1;
          end
        end
        ST_W_SETUP: begin
          state      <= ST_W_STROBE;
          fifo_write <= 1'b1;
        end
        ST_W_STROBE: begin
          state <= ST_W_HOLD;
          if (level != LEVEL_MAX) level <= level + 1'b1;
        end
        ST_W_HOLD: begin
          state       <= ST_IDLE;
          fifo_enable <= 1'b0;
        end
        ST_R_SETUP: begin
          state     <= ST_R_STROBE;
          fifo_read <= 1'b1;
        end
        ST_R_STROBE:  state <= ST_R_HOLD;
        ST_R_HOLD:    state <= ST_R_CAPTURE;
        ST_R_CAPTURE: begin
          state       <= ST_IDLE;
          rd_data     <= fifo_data_out;
          rd_valid    <= 1'b1;
          fifo_enable <= 1'b0;
          if (level != '0) level <= level - 1'b1;
        end
        ST_CLEAR:     state <= ST_IDLE;
        default: begin
          state       <= ST_IDLE;
          fifo_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ram_arbiter.sv
// Directed-plus-random bench for fifo_ram_arbiter with a behavioural fifo_ram
// stub and a scoreboard/arbitration model derived from the access rules.
module tb_fifo_ram_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_valid = 1'b0, b_valid = 1'b0, rd_req = 1'b0, clear = 1'b0;
  logic          a_ready, b_ready, rd_valid, busy;
  logic [DW-1:0] rd_data, fifo_data_in;
  logic          fifo_write, fifo_read, fifo_enable, fifo_reset;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] level;

  fifo_ram_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEVEL_WIDTH(LW)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .clear(clear),
    .fifo_data_in(fifo_data_in), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_enable(fifo_enable), .fifo_reset(fifo_reset),
    .fifo_data_out(fifo_data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .level(level), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural fifo_ram: acts on the strobes at the clock edge ending the strobe cycle.
  logic [DW-1:0] mem [0:DEPTH-1];
  int s_cnt = 0, s_wp = 0, s_rp = 0;
  always @(posedge clock) begin
    if (fifo_reset) begin
      s_cnt <= 0; s_wp <= 0; s_rp <= 0;
    end else if (fifo_enable && fifo_write && s_cnt < DEPTH) begin
      mem[s_wp] <= fifo_data_in;
      s_wp      <= (s_wp + 1) % DEPTH;
      s_cnt     <= s_cnt + 1;
    end else if (fifo_enable && fifo_read && s_cnt > 0) begin
      fifo_data_out <= mem[s_rp];
      s_rp          <= (s_rp + 1) % DEPTH;
      s_cnt         <= s_cnt - 1;
    end
  end
  assign fifo_full  = (s_cnt == DEPTH);
  assign fifo_empty = (s_cnt == 0);

  int n_mutex = 0;
  always @(negedge clock) if (fifo_write && fifo_read) n_mutex <= n_mutex + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [DW-1:0] a_q[$], b_q[$], sb[$];
  int rd_n = 0, exp_level = 0;
  bit cls_ptr = 1'b0, wr_ptr = 1'b0;
  int cyc = 0, n_wr = 0, n_rd = 0, n_clr = 0, n_rdv = 0, n_bready = 0;
  int last_wr_cyc = 0, last_clr_cyc = 0, last_b_cyc = 0;
  int a_cyc[$];
  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    a_valid = (a_q.size() > 0);
    a_data  = a_valid ? a_q[0] : '0;
    b_valid = (b_q.size() > 0);
    b_data  = b_valid ? b_q[0] : '0;
    rd_req  = (rd_n > 0);
  endtask

  task automatic step();
    bit wr_e, rd_e, both_w, en_prev, exp_w, exp_b;
    wr_e    = (a_valid || b_valid) && !fifo_full;
    rd_e    = rd_req && !fifo_empty;
    both_w  = a_valid && b_valid;
    en_prev = fifo_enable;
    @(posedge clock); #1;
    cyc++;
    if (fifo_write) begin n_wr++; last_wr_cyc = cyc; end
    if (fifo_read) n_rd++;
    if (fifo_reset) begin
      n_clr++; last_clr_cyc = cyc;
      check("clear_enable_low", fifo_enable, 0);
      sb.delete(); exp_level = 0;
    end
    if (!en_prev && fifo_enable) begin
      exp_w = (wr_e && rd_e) ? !cls_ptr : wr_e;
      check("class_grant", a_ready || b_ready, exp_w);
      cls_ptr = exp_w;
      if (exp_w) begin
        exp_b = both_w ? wr_ptr : b_valid;
        check("writer_grant", b_ready, exp_b);
        if (both_w) wr_ptr = !exp_b;
      end
    end
    if (a_ready && a_q.size() > 0) begin
      a_cyc.push_back(cyc);
      sb.push_back(a_q.pop_front());
      if (exp_level < DEPTH) exp_level++;
    end
    if (b_ready && b_q.size() > 0) begin
      n_bready++; last_b_cyc = cyc;
      sb.push_back(b_q.pop_front());
      if (exp_level < DEPTH) exp_level++;
    end
    if (rd_valid) begin
      n_rdv++;
      if (sb.size() > 0) check("rd_data", rd_data, sb.pop_front());
      else check("rd_unexpected", rd_valid, 0);
      if (exp_level > 0) exp_level--;
      if (rd_n > 0) rd_n--;
    end
    drive();
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    bit done;
    drive();
    done = (a_q.size() == 0 && b_q.size() == 0 && rd_n == 0 && !busy);
    while (!done && k < budget) begin
      step(); k++;
      done = (a_q.size() == 0 && b_q.size() == 0 && rd_n == 0 && !busy);
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic run_cycles(input int n);
    drive();
    repeat (n) step();
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) a_q.push_back(DW'($urandom_range(0, 255)));
  endtask

  initial begin
    int c0, nw0, nc0, nr0, nb0, nv0, k;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {fifo_enable, fifo_write, fifo_read, fifo_reset}, 0);
    check("rst_pulses", {a_ready, b_ready, rd_valid}, 0);
    check("rst_rd_data", rd_data, 0);
    reset_n = 1'b1;

    // 1: three back-to-back writes from A
    a_q = '{8'h01, 8'h02, 8'h04};
    nw0 = n_wr;
    drain(40, "t1");
    check("t1_ready_count", a_cyc.size(), 3);
    if (a_cyc.size() == 3) begin
      check("t1_spacing0", a_cyc[1] - a_cyc[0], 4);
      check("t1_spacing1", a_cyc[2] - a_cyc[1], 4);
    end
    check("t1_write_strobes", n_wr - nw0, 3);
    check("t1_level", level, 3);

    // 2: both writers held -> A,B alternation, then read everything back
    repeat (4) begin a_q.push_back(8'hAA); b_q.push_back(8'h55); end
    drain(60, "t2w");
    check("t2_level_full", level, exp_level);
    rd_n = 11;
    drain(100, "t2r");
    check("t2_level_empty", level, 0);

    // 3: preload two words, then a reader and writer A contend
    push_rand(2);
    drain(20, "t3pre");
    push_rand(4);
    rd_n = 4;
    drain(100, "t3");
    check("t3_level", level, 2);
    check("t3_level_model", level, exp_level);

    // 4: fill to full, B blocked until one read frees a slot
    push_rand(DEPTH - 2);
    drain(100, "t4fill");
    check("t4_level_full", level, DEPTH);
    b_q.push_back(8'h09);
    nb0 = n_bready;
    run_cycles(20);
    check("t4_no_bready_while_full", n_bready - nb0, 0);
    rd_n = 1;
    drive();
    c0 = cyc;
    drain(40, "t4");
    check("t4_b_accepted", n_bready - nb0, 1);
    check("t4_b_latency_ok", (last_b_cyc - c0) <= 10, 1);
    check("t4_level_full_again", level, DEPTH);

    // 5: empty FIFO stalls the reader until A supplies a word
    rd_n = DEPTH;
    drain(200, "t5drain");
    check("t5_level_zero", level, 0);
    rd_n = 1;
    nr0 = n_rd;
    run_cycles(15);
    check("t5_no_read_strobe", n_rd - nr0, 0);
    check("t5_idle_while_stalled", busy, 0);
    a_q.push_back(8'h70);
    drain(40, "t5");
    check("t5_rd_data", rd_data, 8'h70);
    check("t5_level", level, 0);

    // 6: clear arriving mid-write with level 5
    push_rand(5);
    drain(40, "t6pre");
    check("t6_level5", level, 5);
    push_rand(1);
    nw0 = n_wr; nc0 = n_clr;
    drive();
    k = 0;
    while (!a_ready && k < 10) begin step(); k++; end
    check("t6_write_started", a_ready, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drain(20, "t6");
    run_cycles(3);
    check("t6_write_completed", n_wr - nw0, 1);
    check("t6_one_clear", n_clr - nc0, 1);
    check("t6_clear_after_write", last_clr_cyc > last_wr_cyc, 1);
    check("t6_level", level, 0);

    // 7: reset asserted during R_STROBE
    push_rand(1);
    drain(20, "t7pre");
    rd_n = 1;
    drive();
    k = 0;
    while (!fifo_read && k < 10) begin step(); k++; end
    check("t7_in_strobe", fifo_read, 1);
    reset_n = 1'b0;
    #1;
    check("t7_strobes_drop", {fifo_enable, fifo_write, fifo_read}, 0);
    check("t7_busy", busy, 0);
    check("t7_level", level, 0);
    check("t7_rd_data", rd_data, 0);
    rd_n = 0;
    drive();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    cls_ptr = 1'b0; wr_ptr = 1'b0; exp_level = 0;
    nv0 = n_rdv;
    run_cycles(8);
    check("t7_no_rd_valid", n_rdv - nv0, 0);

    // The aborted word is still in fifo_ram while level reads 0: level must not wrap.
    rd_n = 1;
    drain(20, "t8");
    check("t8_rd_valid", n_rdv - nv0, 1);
    check("t8_level_saturates", level, 0);

    check("strobe_mutex", n_mutex, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
